// File: rtl/tcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcm_pkg
// Description : Shared TCM constants plus the grant and clear-state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package tcm_pkg;

    localparam int TCM_ADDR_W = 14;
    localparam int TCM_DEPTH  = 8192;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CLR  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_LDR  = 2'd3
    } grant_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tcm_port0_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : tcm_port0_arb_if
// Description : Requester, clear-control and RAM port-0 signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface tcm_port0_arb_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wr;
    logic              cpu_accept;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;

    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic [3:0]        ldr_wr;
    logic              ldr_accept;
    logic              ldr_ack;
    logic [31:0]       ldr_rdata;

    logic              clr_start;
    logic              clr_busy;

    logic [ADDR_W-1:0] ram_addr0;
    logic [31:0]       ram_wdata0;
    logic [3:0]        ram_wr0;
    logic [31:0]       ram_rdata0;

    // Environment side: requesters plus the RAM read-data return.
    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_wr,
        input  cpu_accept, cpu_ack, cpu_rdata,
        output ldr_req, ldr_addr, ldr_wdata, ldr_wr,
        input  ldr_accept, ldr_ack, ldr_rdata,
        output clr_start,
        input  clr_busy,
        input  ram_addr0, ram_wdata0, ram_wr0,
        output ram_rdata0
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_wr,
        output cpu_accept, cpu_ack, cpu_rdata,
        input  ldr_req, ldr_addr, ldr_wdata, ldr_wr,
        output ldr_accept, ldr_ack, ldr_rdata,
        input  clr_start,
        output clr_busy,
        output ram_addr0, ram_wdata0, ram_wr0,
        input  ram_rdata0
    );
endinterface
`default_nettype wire

// File: rtl/tcm_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : tcm_clear_seq
// Description : Zero-fill sequencer; walks addr 0..DEPTH-1 once per start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_clear_seq
    import tcm_pkg::*;
#(
    parameter int ADDR_W = TCM_ADDR_W,
    parameter int DEPTH  = TCM_DEPTH
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    output logic                   busy,
    output logic [ADDR_W-1:0]      addr,
    output logic                   last
);
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // A start pulse while already clearing is dropped: no restart.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_next = ST_CLEAR;
            ST_CLEAR: if (w_last) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state == ST_CLEAR);
        w_last = busy && (r_cnt == c_cnt_max);
        last   = w_last;
        addr   = ADDR_W'(r_cnt);
    end

endmodule
`default_nettype wire

// File: rtl/tcm_port0_arb.sv
`default_nettype none
// ============================================================================
// Module      : tcm_port0_arb
// Description : TCM port-0 arbiter for CPU, loader and clear engine with
//               starvation guard and one-cycle registered response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tcm_port0_arb
    import tcm_pkg::*;
#(
    parameter int ADDR_W     = TCM_ADDR_W,
    parameter int DEPTH      = TCM_DEPTH,
    parameter int STARVE_MAX = 8
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    tcm_port0_arb_if.slave   bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] c_starve_max = SC_W'(STARVE_MAX);

    logic              w_clr_busy;
    logic              w_clr_last;
    logic [ADDR_W-1:0] w_clr_addr;
    grant_t            w_grant;
    grant_t            r_owner;
    logic [SC_W-1:0]   r_starve_cnt;

    tcm_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk   (clk_i),
        .rst   (rst_i),
        .start (bus.clr_start),
        .busy  (w_clr_busy),
        .addr  (w_clr_addr),
        .last  (w_clr_last)
    );

    // Reset suppresses every grant, including an in-flight clear write.
    always_comb begin
        w_grant = GNT_NONE;
        if (rst_i) begin
            w_grant = GNT_NONE;
        end else if (w_clr_busy) begin
            w_grant = GNT_CLR;
        end else if (bus.cpu_req && bus.ldr_req) begin
            w_grant = (r_starve_cnt == c_starve_max) ? GNT_LDR : GNT_CPU;
        end else if (bus.cpu_req) begin
            w_grant = GNT_CPU;
        end else if (bus.ldr_req) begin
            w_grant = GNT_LDR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !bus.ldr_req || w_grant == GNT_LDR) begin
            r_starve_cnt <= '0;
        end else if (w_grant == GNT_CPU) begin
            r_starve_cnt <= r_starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner <= GNT_NONE;
        end else if (w_grant == GNT_CPU || w_grant == GNT_LDR) begin
            r_owner <= w_grant;
        end else begin
            r_owner <= GNT_NONE;
        end
    end

    always_comb begin
        bus.clr_busy   = w_clr_busy;
        bus.cpu_accept = (w_grant == GNT_CPU);
        bus.ldr_accept = (w_grant == GNT_LDR);
        bus.ram_addr0  = '0;
        bus.ram_wdata0 = '0;
        bus.ram_wr0    = '0;
        case (w_grant)
            GNT_CLR: begin
                bus.ram_addr0  = w_clr_addr;
                bus.ram_wr0    = 4'hF;
            end
            GNT_CPU: begin
                bus.ram_addr0  = bus.cpu_addr;
                bus.ram_wdata0 = bus.cpu_wdata;
                bus.ram_wr0    = bus.cpu_wr;
            end
            GNT_LDR: begin
                bus.ram_addr0  = bus.ldr_addr;
                bus.ram_wdata0 = bus.ldr_wdata;
                bus.ram_wr0    = bus.ldr_wr;
            end
            default: ;
        endcase
    end

    // Read data is zeroed toward whichever requester does not own the ack.
    always_comb begin
        bus.cpu_ack   = (r_owner == GNT_CPU);
        bus.ldr_ack   = (r_owner == GNT_LDR);
        bus.cpu_rdata = bus.cpu_ack ? bus.ram_rdata0 : 32'h0;
        bus.ldr_rdata = bus.ldr_ack ? bus.ram_rdata0 : 32'h0;
    end

    logic w_unused;
    assign w_unused = w_clr_last;

endmodule
`default_nettype wire

// File: tb/tb_tcm_port0_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcm_port0_arb
// Description : Directed self-checking bench for tcm_port0_arb with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcm_port0_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tcm_port0_arb_if #(.ADDR_W(14)) bus();

    tcm_port0_arb #(
        .ADDR_W     (14),
        .DEPTH      (8192),
        .STARVE_MAX (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Read-first, byte-enabled, one-cycle registered RAM.
    logic [31:0] mem [0:8191];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        ram_q <= mem[bus.ram_addr0[12:0]];
        for (int b = 0; b < 4; b++)
            if (bus.ram_wr0[b]) mem[bus.ram_addr0[12:0]][b*8 +: 8] <= bus.ram_wdata0[b*8 +: 8];
    end
    assign bus.ram_rdata0 = ram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic req, input logic [13:0] addr, input logic [31:0] wd, input logic [3:0] wr);
        bus.cpu_req = req; bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.cpu_wr = wr;
    endtask

    task automatic set_ldr(input logic req, input logic [13:0] addr, input logic [31:0] wd, input logic [3:0] wr);
        bus.ldr_req = req; bus.ldr_addr = addr; bus.ldr_wdata = wd; bus.ldr_wr = wr;
    endtask

    task automatic run_clear(output int cycles);
        bit done = 1'b0;
        cycles = 0;
        tick(); bus.clr_start = 1'b1;
        tick(); bus.clr_start = 1'b0;
        for (int n = 0; n < 9000 && !done; n++) begin
            half();
            if (bus.clr_busy) cycles++;
            else done = 1'b1;
            if (!done) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.clr_start = 1'b0;
        set_cpu(1'b1, 14'h5, 32'h1234_5678, 4'hF);
        set_ldr(1'b1, 14'h6, 32'h0, 4'h0);
        tick(); half();
        checks++; if (bus.cpu_accept !== 1'b0) begin errors++; $display("FAIL rst_cpu_accept: got %b expected 0", bus.cpu_accept); end
        checks++; if (bus.ldr_accept !== 1'b0) begin errors++; $display("FAIL rst_ldr_accept: got %b expected 0", bus.ldr_accept); end
        checks++; if (bus.ram_wr0 !== 4'h0) begin errors++; $display("FAIL rst_ram_wr: got %h expected 0", bus.ram_wr0); end
        tick(); rst = 1'b0;
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0); set_ldr(1'b0, 14'h0, 32'h0, 4'h0);
        half();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.ldr_ack !== 1'b0) begin errors++; $display("FAIL rst_acks: got %b%b expected 00", bus.cpu_ack, bus.ldr_ack); end
        checks++; if (bus.cpu_rdata !== 32'h0 || bus.ldr_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h %h expected 0 0", bus.cpu_rdata, bus.ldr_rdata); end
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.clr_busy); end
        checks++; if (bus.ram_addr0 !== 14'h0 || bus.ram_wdata0 !== 32'h0 || bus.ram_wr0 !== 4'h0) begin errors++; $display("FAIL rst_ram_idle: got addr %h data %h wr %h expected 0 0 0", bus.ram_addr0, bus.ram_wdata0, bus.ram_wr0); end
    endtask

    task automatic test_cpu_rw();
        tick(); set_cpu(1'b1, 14'h10, 32'h1111_1111, 4'hF); half();
        checks++; if (bus.cpu_accept !== 1'b1) begin errors++; $display("FAIL rw_accept: got %b expected 1", bus.cpu_accept); end
        checks++; if (bus.ram_addr0 !== 14'h10 || bus.ram_wr0 !== 4'hF || bus.ram_wdata0 !== 32'h1111_1111) begin errors++; $display("FAIL rw_ram_drive: got addr %h wr %h data %h expected 0010 f 11111111", bus.ram_addr0, bus.ram_wr0, bus.ram_wdata0); end
        tick(); set_cpu(1'b1, 14'h10, 32'hDEAD_BEEF, 4'hF); half();
        checks++; if (bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL rw_write_ack: got %b expected 1", bus.cpu_ack); end
        tick(); set_cpu(1'b1, 14'h10, 32'h0, 4'h0); half();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h1111_1111) begin errors++; $display("FAIL rw_write_prior: got ack %b data %h expected 1 11111111", bus.cpu_ack, bus.cpu_rdata); end
        tick(); set_cpu(1'b0, 14'h0, 32'h0, 4'h0); half();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_read: got ack %b data %h expected 1 deadbeef", bus.cpu_ack, bus.cpu_rdata); end
        checks++; if (bus.ldr_ack !== 1'b0 || bus.ldr_rdata !== 32'h0) begin errors++; $display("FAIL rw_ldr_quiet: got ack %b data %h expected 0 0", bus.ldr_ack, bus.ldr_rdata); end
        tick(); half();
        checks++; if (bus.cpu_ack !== 1'b0 || bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rw_idle_ack: got ack %b data %h expected 0 0", bus.cpu_ack, bus.cpu_rdata); end
    endtask

    task automatic test_byte_en();
        tick(); set_cpu(1'b1, 14'h20, 32'h1122_3344, 4'hF);
        tick(); set_cpu(1'b1, 14'h20, 32'h0000_00AA, 4'h1);
        tick(); set_cpu(1'b1, 14'h20, 32'h0, 4'h0); half();
        checks++; if (bus.cpu_rdata !== 32'h1122_3344) begin errors++; $display("FAIL be_write_prior: got %h expected 11223344", bus.cpu_rdata); end
        tick(); set_cpu(1'b0, 14'h0, 32'h0, 4'h0); half();
        checks++; if (bus.cpu_rdata !== 32'h1122_33AA) begin errors++; $display("FAIL be_merge: got %h expected 112233aa", bus.cpu_rdata); end
    endtask

    task automatic test_loader();
        tick(); set_ldr(1'b1, 14'h30, 32'hCAFE_F00D, 4'hF); half();
        checks++; if (bus.ldr_accept !== 1'b1 || bus.cpu_accept !== 1'b0) begin errors++; $display("FAIL ldr_accept: got ldr %b cpu %b expected 1 0", bus.ldr_accept, bus.cpu_accept); end
        tick(); set_ldr(1'b1, 14'h30, 32'h0, 4'h0); half();
        checks++; if (bus.ldr_ack !== 1'b1 || bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL ldr_write_ack: got ldr %b cpu %b expected 1 0", bus.ldr_ack, bus.cpu_ack); end
        tick(); set_ldr(1'b0, 14'h0, 32'h0, 4'h0); half();
        checks++; if (bus.ldr_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ldr_read: got %h expected cafef00d", bus.ldr_rdata); end
    endtask

    task automatic test_contention();
        logic prev_c = 1'b0;
        logic prev_l = 1'b0;
        logic exp_l;
        tick(); set_cpu(1'b1, 14'h10, 32'h0, 4'h0); set_ldr(1'b1, 14'h20, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            half();
            exp_l = ((i % 9) == 8);
            checks++; if (bus.cpu_accept !== !exp_l || bus.ldr_accept !== exp_l) begin errors++; $display("FAIL cont_grant[%0d]: got cpu %b ldr %b expected %b %b", i, bus.cpu_accept, bus.ldr_accept, !exp_l, exp_l); end
            if (i > 0) begin
                checks++; if (bus.cpu_ack !== prev_c || bus.ldr_ack !== prev_l) begin errors++; $display("FAIL cont_ack[%0d]: got cpu %b ldr %b expected %b %b", i, bus.cpu_ack, bus.ldr_ack, prev_c, prev_l); end
                checks++; if (bus.cpu_rdata !== (prev_c ? 32'hDEAD_BEEF : 32'h0) || bus.ldr_rdata !== (prev_l ? 32'h1122_33AA : 32'h0)) begin errors++; $display("FAIL cont_data[%0d]: got cpu %h ldr %h", i, bus.cpu_rdata, bus.ldr_rdata); end
            end
            prev_c = !exp_l; prev_l = exp_l;
            tick();
        end
        set_cpu(1'b0, 14'h0, 32'h0, 4'h0); set_ldr(1'b0, 14'h0, 32'h0, 4'h0);
        half();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.ldr_ack !== 1'b0 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cont_tail: got cpu %b ldr %b data %h expected 1 0 deadbeef", bus.cpu_ack, bus.ldr_ack, bus.cpu_rdata); end
    endtask

    task automatic test_clear();
        int  busy_cnt = 0;
        int  bad_acc  = 0;
        int  bad_addr = 0;
        bit  done     = 1'b0;
        tick(); set_cpu(1'b1, 14'h0000, 32'h5A5A_5A5A, 4'hF);
        tick(); set_cpu(1'b1, 14'h1FFF, 32'h5A5A_5A5A, 4'hF);
        tick(); set_cpu(1'b0, 14'h0, 32'h0, 4'h0); bus.clr_start = 1'b1; half();
        checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL clr_start_cycle_busy: got %b expected 0", bus.clr_busy); end
        tick(); bus.clr_start = 1'b0; set_cpu(1'b1, 14'h0, 32'h0, 4'h0); set_ldr(1'b1, 14'h5, 32'h0, 4'h0);
        for (int n = 0; n < 9000 && !done; n++) begin
            half();
            if (bus.clr_busy) begin
                if (bus.cpu_accept || bus.ldr_accept) bad_acc++;
                if (bus.ram_addr0 !== 14'(busy_cnt) || bus.ram_wr0 !== 4'hF || bus.ram_wdata0 !== 32'h0) bad_addr++;
                busy_cnt++;
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                tick();
                bus.clr_start = (busy_cnt == 100);
            end
        end
        checks++; if (busy_cnt != 8192) begin errors++; $display("FAIL clr_length: got %0d expected 8192", busy_cnt); end
        checks++; if (bad_acc != 0) begin errors++; $display("FAIL clr_no_accept: got %0d accepts expected 0", bad_acc); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL clr_drive: got %0d bad cycles expected 0", bad_addr); end
        checks++; if (bus.cpu_accept !== 1'b1) begin errors++; $display("FAIL clr_after_accept: got %b expected 1", bus.cpu_accept); end
        tick(); set_ldr(1'b0, 14'h0, 32'h0, 4'h0); set_cpu(1'b1, 14'h1FFF, 32'h0, 4'h0); half();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL clr_word0: got ack %b data %h expected 1 0", bus.cpu_ack, bus.cpu_rdata); end
        tick(); set_cpu(1'b0, 14'h0, 32'h0, 4'h0); half();
        checks++; if (bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL clr_word8191: got ack %b data %h expected 1 0", bus.cpu_ack, bus.cpu_rdata); end
    endtask

    task automatic test_reset_mid_clear();
        bit found = 1'b0;
        int cycles;
        tick(); bus.clr_start = 1'b1;
        tick(); bus.clr_start = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            half();
            if (bus.clr_busy && bus.ram_addr0 == 14'd100) found = 1'b1;
            else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL rmc_reach100: got not reached expected clr_cnt 100"); end
        rst = 1'b1; set_cpu(1'b1, 14'h10, 32'h0, 4'h0);
        #1;
        checks++; if (bus.ram_wr0 !== 4'h0 || bus.cpu_accept !== 1'b0) begin errors++; $display("FAIL rmc_forced: got wr %h accept %b expected 0 0", bus.ram_wr0, bus.cpu_accept); end
        tick(); rst = 1'b0; set_cpu(1'b0, 14'h0, 32'h0, 4'h0); half();
        checks++; if (bus.clr_busy !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.ldr_ack !== 1'b0 || bus.ram_wr0 !== 4'h0) begin errors++; $display("FAIL rmc_after: got busy %b acks %b%b wr %h expected 0 00 0", bus.clr_busy, bus.cpu_ack, bus.ldr_ack, bus.ram_wr0); end
        run_clear(cycles);
        checks++; if (cycles != 8192) begin errors++; $display("FAIL rmc_fresh_len: got %0d expected 8192", cycles); end
    endtask

    task automatic test_accept_on_clear_start();
        bit done = 1'b0;
        tick(); set_cpu(1'b1, 14'h10, 32'hDEAD_BEEF, 4'hF);
        tick(); set_cpu(1'b1, 14'h10, 32'h0, 4'h0); bus.clr_start = 1'b1; half();
        checks++; if (bus.cpu_accept !== 1'b1 || bus.clr_busy !== 1'b0) begin errors++; $display("FAIL acs_accept: got accept %b busy %b expected 1 0", bus.cpu_accept, bus.clr_busy); end
        tick(); set_cpu(1'b0, 14'h0, 32'h0, 4'h0); bus.clr_start = 1'b0; half();
        checks++; if (bus.clr_busy !== 1'b1 || bus.cpu_ack !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL acs_ack: got busy %b ack %b data %h expected 1 1 deadbeef", bus.clr_busy, bus.cpu_ack, bus.cpu_rdata); end
        for (int n = 0; n < 9000 && !done; n++) begin
            tick(); half();
            if (!bus.clr_busy) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL acs_clear_end: got busy stuck expected clear to finish"); end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_byte_en();
        test_loader();
        test_contention();
        test_clear();
        test_reset_mid_clear();
        test_accept_on_clear_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
